// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running h/v counters plus registered decode of
// pixel coordinates, blanking, sync levels and line/frame strobes.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       pixel_clk,
   input  logic       resetSwitch,
   input  logic       pix_en,
   output logic [9:0] col,
   output logic [8:0] row,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_end,
   output logic       frame_start
);

   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_vis;
   logic       v_vis;
   logic       vis;
   logic       h_in_sync;
   logic       v_in_sync;

   always_ff @(posedge pixel_clk or negedge resetSwitch) begin
      if (!resetSwitch) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   always_comb begin
      h_vis     = (h_cnt < H_VIS_END);
      v_vis     = (v_cnt < V_VIS_END);
      vis       = h_vis && v_vis;
      h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
      v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
   end

   // Outputs sample the pre-increment counters, so every output lags the
   // counters by one enabled tick but all outputs stay aligned to each other.
   always_ff @(posedge pixel_clk or negedge resetSwitch) begin
      if (!resetSwitch) begin
         col         <= '0;
         row         <= '0;
         video_on    <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         col         <= vis ? h_cnt : 10'd0;
         row         <= vis ? v_cnt[8:0] : 9'd0;
         video_on    <= vis;
         hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
         vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
         line_end    <= (h_cnt == H_LAST);
         frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: one default-timing instance and one shrunken-timing instance
// driven by the same random pix_en/reset stream, checked against a position model.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] col;
      logic [8:0] row;
      logic       video_on;
      logic       hsync;
      logic       vsync;
      logic       line_end;
      logic       frame_start;
   } vga_out_t;

   localparam vga_out_t RESET_OUT = '{col: 10'd0, row: 9'd0, video_on: 1'b0, hsync: 1'b1,
                                      vsync: 1'b1, line_end: 1'b0, frame_start: 1'b0};

   localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
   localparam int D_VA = 480, D_VF = 10, D_VS = 2,  D_VB = 33;
   localparam int S_HA = 16,  S_HF = 2,  S_HS = 3,  S_HB = 3;
   localparam int S_VA = 10,  S_VF = 2,  S_VS = 2,  S_VB = 3;
   localparam int D_FRAME = (D_HA + D_HF + D_HS + D_HB) * (D_VA + D_VF + D_VS + D_VB);
   localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
   localparam int RUN_CYCLES = 20000;

   logic       pixel_clk = 1'b0;
   logic       resetSwitch;
   logic       pix_en;

   logic [9:0] d_col, s_col;
   logic [8:0] d_row, s_row;
   logic       d_von, d_hs, d_vs, d_le, d_fs;
   logic       s_von, s_hs, s_vs, s_le, s_fs;
   vga_out_t   d_out, s_out;

   vga_out_t   d_q[$];
   vga_out_t   s_q[$];
   vga_out_t   d_cur, s_cur;
   int         d_pos, s_pos;
   int         checks = 0;
   int         passed = 0;
   logic       prev_rst_n = 1'b0;

   always #5 pixel_clk = ~pixel_clk;

   vga_sync_gen u_def (
      .pixel_clk(pixel_clk), .resetSwitch(resetSwitch), .pix_en(pix_en),
      .col(d_col), .row(d_row), .video_on(d_von), .hsync(d_hs), .vsync(d_vs),
      .line_end(d_le), .frame_start(d_fs)
   );

   vga_sync_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
   ) u_small (
      .pixel_clk(pixel_clk), .resetSwitch(resetSwitch), .pix_en(pix_en),
      .col(s_col), .row(s_row), .video_on(s_von), .hsync(s_hs), .vsync(s_vs),
      .line_end(s_le), .frame_start(s_fs)
   );

   assign d_out = '{d_col, d_row, d_von, d_hs, d_vs, d_le, d_fs};
   assign s_out = '{s_col, s_row, s_von, s_hs, s_vs, s_le, s_fs};

   // Expected outputs for the tick that lands on frame position p (0 = pixel (0,0)).
   function automatic vga_out_t model(input int p, input int ha, input int hf, input int hs,
                                      input int hb, input int va, input int vf, input int vs,
                                      input int vb);
      int ht = ha + hf + hs + hb;
      int vt = va + vf + vs + vb;
      int h  = p % ht;
      int v  = (p / ht) % vt;
      logic vis = (h < ha) && (v < va);
      vga_out_t o;
      o.col         = vis ? 10'(h) : 10'd0;
      o.row         = vis ? 9'(v) : 9'd0;
      o.video_on    = vis;
      o.hsync       = (h >= ha + hf && h < ha + hf + hs) ? 1'b0 : 1'b1;
      o.vsync       = (v >= va + vf && v < va + vf + vs) ? 1'b0 : 1'b1;
      o.line_end    = (h == ht - 1);
      o.frame_start = (h == 0) && (v == 0);
      return o;
   endfunction

   task automatic checkOutput(input string name, input vga_out_t act, input vga_out_t exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s t=%0t: got col=%0d row=%0d von=%b hs=%b vs=%b le=%b fs=%b, expected col=%0d row=%0d von=%b hs=%b vs=%b le=%b fs=%b",
                  name, $time, act.col, act.row, act.video_on, act.hsync, act.vsync,
                  act.line_end, act.frame_start, exp.col, exp.row, exp.video_on,
                  exp.hsync, exp.vsync, exp.line_end, exp.frame_start);
      end
   endtask

   // Drives one tick at the falling edge and queues what the next rising edge must produce.
   task automatic applyStimulus(input logic rst_n_v, input logic en_v);
      @(negedge pixel_clk);
      resetSwitch = rst_n_v;
      pix_en      = en_v;
      if (!rst_n_v) begin
         d_pos = 0;
         s_pos = 0;
         d_cur = RESET_OUT;
         s_cur = RESET_OUT;
         if (prev_rst_n) begin
            #1;
            checkOutput("async_reset_def", d_out, RESET_OUT);
            checkOutput("async_reset_small", s_out, RESET_OUT);
         end
      end else if (en_v) begin
         d_cur = model(d_pos, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB);
         s_cur = model(s_pos, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
         d_pos = (d_pos + 1) % D_FRAME;
         s_pos = (s_pos + 1) % S_FRAME;
      end
      prev_rst_n = rst_n_v;
      d_q.push_back(d_cur);
      s_q.push_back(s_cur);
   endtask

   initial begin
      forever begin
         @(posedge pixel_clk);
         #1;
         if (d_q.size() > 0) checkOutput("tick_def", d_out, d_q.pop_front());
         if (s_q.size() > 0) checkOutput("tick_small", s_out, s_q.pop_front());
      end
   end

   initial begin
      logic rst_v;
      logic en_v;
      resetSwitch = 1'b0;
      pix_en      = 1'b1;
      d_cur       = RESET_OUT;
      s_cur       = RESET_OUT;
      d_pos       = 0;
      s_pos       = 0;
      repeat (4) applyStimulus(1'b0, 1'b1);
      for (int i = 0; i < RUN_CYCLES; i++) begin
         rst_v = !((i >= 9000 && i < 9003) || (i >= 15123 && i < 15125));
         if (i < 1500)
            en_v = 1'b1;
         else if (i >= 1500 && i < 1504)
            en_v = (i == 1500 || i == 1503);
         else
            en_v = ($urandom_range(0, 3) != 0);
         applyStimulus(rst_v, en_v);
      end
      repeat (3) @(posedge pixel_clk);
      #2;
      checks++;
      if (d_q.size() == 0 && s_q.size() == 0)
         passed++;
      else
         $display("[TB] FAIL drain: got %0d/%0d entries left, expected 0/0", d_q.size(), s_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
